data_memory_responder: RTL and testbench

Memory-side responder for the data cache controller. It accepts read (block fill) and write-through requests, waits a fixed access latency, then either streams a cache block one word per cycle or commits a single word and acknowledges it. It backs the data cache in simulation and FPGA builds, and sits between the data cache controller and the backing word array it owns.

---
 rtl/data_memory_responder.sv | 142 ++++++++++++++
 tb/tb_data_memory_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Fixed-latency memory responder: block-read bursts and single-word write-through with ack.
// Optional MEM_RANGE_CHECK_EN flags out-of-range or misaligned accesses on err.
module data_memory_responder #(
  parameter int LATENCY    = 4,
  parameter int BLOCKWORDS = 4,
  parameter int DEPTHWORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        wack,
  output logic        err
);

  localparam int AW = $clog2(DEPTHWORDS);
  localparam int BW = $clog2(BLOCKWORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_WRITE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_beat;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_bad;
  logic            r_busy;
  logic            r_rvalid;
  logic [31:0]     r_rdata;
  logic            r_wack;
  logic            r_err;
  logic [31:0]     r_mem [DEPTHWORDS];

  logic            w_bad;
  logic [BW-1:0]   w_next_beat;
  logic [AW-1:0]   w_rd_idx;

`ifdef MEM_RANGE_CHECK_EN
  assign w_bad = (|addr[31:AW+2]) || (we && (|addr[1:0]));
`else
  logic w_unused_bits;
  assign w_bad         = 1'b0;
  assign w_unused_bits = ^{addr[31:AW+2], addr[1:0]};
`endif

  // The array is read one cycle ahead so rdata lines up with rvalid.
  always_comb begin
    w_next_beat = '0;
    if (r_state == S_BURST) w_next_beat = r_beat + BW'(1);
    w_rd_idx = {r_idx[AW-1:BW], w_next_beat};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_beat   <= '0;
      r_we     <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_bad    <= 1'b0;
      r_busy   <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_wack   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_wack   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_idx   <= addr[AW+1:2];
            r_wdata <= wdata;
            r_bad   <= w_bad;
            r_cnt   <= CW'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (r_we) begin
              r_wack  <= 1'b1;
              r_err   <= r_bad;
              r_state <= S_WRITE;
            end else begin
              r_beat   <= '0;
              r_rvalid <= 1'b1;
              r_rdata  <= r_bad ? '0 : r_mem[w_rd_idx];
              r_err    <= r_bad;
              r_state  <= S_BURST;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_BURST: begin
          if (r_beat == BW'(BLOCKWORDS - 1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_beat   <= w_next_beat;
            r_rvalid <= 1'b1;
            r_rdata  <= r_bad ? '0 : r_mem[w_rd_idx];
            r_err    <= r_bad;
          end
        end
        S_WRITE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Array has no reset; a reset in WRITE must still block the commit.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_WRITE) && !r_bad) r_mem[r_idx] <= r_wdata;
  end

  assign busy   = r_busy;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign wack   = r_wack;
  assign err    = r_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (LATENCY=4, BLOCKWORDS=4, DEPTHWORDS=1024).
module tb_data_memory_responder;
  localparam int L = 4;
  localparam int B = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        rvalid;
  logic [31:0] rdata;
  logic        wack;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [1024];

  data_memory_responder #(.LATENCY(L), .BLOCKWORDS(B), .DEPTHWORDS(1024)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .rvalid(rvalid), .rdata(rdata), .wack(wack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_rvalid"}, rvalid, 1'b0);
    chk1({tag, "_wack"}, wack, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk32({tag, "_rdata"}, rdata, 32'h0);
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge of the next idle cycle.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic exp_err,
                          input logic keep);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    if (!keep) req = 1'b0;
    for (int k = 0; k < L; k++) begin
      chk1("wr_busy_wait", busy, 1'b1);
      chk1("wr_wack_early", wack, 1'b0);
      @(negedge clk);
    end
    chk1("wr_wack", wack, 1'b1);
    chk1("wr_busy_ack", busy, 1'b1);
    chk1("wr_err", err, exp_err);
    chk1("wr_rvalid", rvalid, 1'b0);
    @(negedge clk);
    chk1("wr_busy_after", busy, 1'b0);
    chk1("wr_wack_after", wack, 1'b0);
    if (!exp_err) model[a[11:2]] = d;
  endtask

  task automatic do_read(input logic [31:0] a, input logic inject);
    int base;
    base = int'(a[11:2]) & ~(B - 1);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < L; k++) begin
      chk1("rd_busy_wait", busy, 1'b1);
      chk1("rd_rvalid_early", rvalid, 1'b0);
      chk32("rd_rdata_wait", rdata, 32'h0);
      if (inject && k == 2) begin
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1111_1111;
      end
      if (inject && k == 3) req = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < B; i++) begin
      chk1("rd_rvalid", rvalid, 1'b1);
      chk1("rd_busy_beat", busy, 1'b1);
      chk1("rd_err", err, 1'b0);
      chk32("rd_rdata", rdata, model[base + i]);
      @(negedge clk);
    end
    chk1("rd_busy_after", busy, 1'b0);
    chk1("rd_rvalid_after", rvalid, 1'b0);
    chk32("rd_rdata_after", rdata, 32'h0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    idle_check("reset");
    reset = 1'b0;

    // Known contents for blocks 0x00..0x40.
    for (int w = 0; w < 20; w++) begin
      do_write(32'(w * 4), 32'hA500_0000 | 32'(w * 4), 1'b0, 1'b0);
    end

    // Write-through then block read returning words 0x10..0x1C.
    do_write(32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_read(32'h0000_0018, 1'b0);

    // Write request during a read burst must be dropped.
    do_read(32'h0000_0020, 1'b1);
    do_read(32'h0000_0020, 1'b0);

    // Back-to-back with req held high between operations.
    do_write(32'h0000_0030, 32'h55AA_0030, 1'b0, 1'b1);
    do_read(32'h0000_0030, 1'b0);
    do_write(32'h0000_0034, 32'h66BB_0034, 1'b0, 1'b1);
    do_read(32'h0000_0034, 1'b0);

    // Reset in the middle of a write: no ack, no commit.
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_check("midreset");
    for (int k = 0; k < L + 1; k++) begin
      @(negedge clk);
      chk1("midreset_wack", wack, 1'b0);
      chk1("midreset_busy", busy, 1'b0);
    end
    do_read(32'h0000_0040, 1'b0);

    // Address above the array.
`ifdef MEM_RANGE_CHECK_EN
    do_write(32'h0000_1000, 32'h1234_5678, 1'b1, 1'b0);
`else
    do_write(32'h0000_1000, 32'h1234_5678, 1'b0, 1'b0);
`endif
    do_read(32'h0000_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
